// File: rtl/loop_control_fsm.sv
// loop_control_fsm: edge-triggered N-chunk transport controller for the looper
module loop_control_fsm #(
  parameter int NUM_CHUNKS  = 8,
  parameter int ADDR_W      = 23,
  parameter int CHUNK_LOG2  = 20,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_rec_btn,
  input  logic                  i_play_btn,
  input  logic                  i_mix_btn,
  input  logic                  i_stop_btn,
  input  logic [NUM_CHUNKS-1:0] i_trig,
  input  logic [NUM_CHUNKS-1:0] i_sw,
  input  logic [NUM_CHUNKS-1:0] i_mute,
  input  logic [1:0]            i_speed,
  input  logic                  i_rec_done,
  input  logic                  i_play_done,
  input  logic                  i_mix_done,
  output logic [2:0]            o_mode,
  output logic                  o_rec_start,
  output logic                  o_play_start,
  output logic                  o_mix_start,
  output logic                  o_stop,
  output logic [ADDR_W-1:0]     o_rec_addr,
  output logic [ADDR_W-1:0]     o_play_addr,
  output logic [ADDR_W-1:0]     o_mix_rec_addr,
  output logic [1:0]            o_play_speed,
  output logic [NUM_CHUNKS-1:0] o_mix_mask,
  output logic                  o_mix_rec_en,
  output logic                  o_err
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [2:0] {IDLE, REC_ARM, REC, PLAY, MIX, DRAIN} state_t;
  state_t state_q, src_q;
  logic rec_q, play_q, mix_q, stop_q;
  logic [NUM_CHUNKS-1:0] trig_q, trig_e;
  logic [WD_W-1:0] wd_q;
  logic rec_e, play_e, mix_e, stop_e, sw_one, drain_done, wd_end;
  logic [ADDR_W-1:0] sw_addr, trig_addr;
  // lowest set bit selects the chunk; for a one-hot vector that is the only bit
  function automatic logic [ADDR_W-1:0] base(input logic [NUM_CHUNKS-1:0] v);
    base = '0;
    for (int i = NUM_CHUNKS - 1; i >= 0; i--)
      if (v[i]) base = ADDR_W'(i) << CHUNK_LOG2;
  endfunction
  assign rec_e      = i_rec_btn & ~rec_q;
  assign play_e     = i_play_btn & ~play_q;
  assign mix_e      = i_mix_btn & ~mix_q;
  assign stop_e     = i_stop_btn & ~stop_q;
  assign trig_e     = i_trig & ~trig_q & ~i_mute;
  assign sw_one     = $onehot(i_sw);
  assign sw_addr    = base(i_sw);
  assign trig_addr  = base(trig_e);
  assign wd_end     = wd_q == WD_W'(TIMEOUT_CYC - 1);
  assign drain_done = (src_q == REC && i_rec_done) || (src_q == PLAY && i_play_done) ||
                      (src_q == MIX && i_mix_done);
  assign o_mode     = state_q;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q        <= IDLE;
      src_q          <= IDLE;
      rec_q          <= 1'b0;
      play_q         <= 1'b0;
      mix_q          <= 1'b0;
      stop_q         <= 1'b0;
      trig_q         <= '0;
      wd_q           <= '0;
      o_rec_start    <= 1'b0;
      o_play_start   <= 1'b0;
      o_mix_start    <= 1'b0;
      o_stop         <= 1'b0;
      o_rec_addr     <= '0;
      o_play_addr    <= '0;
      o_mix_rec_addr <= '0;
      o_play_speed   <= '0;
      o_mix_mask     <= '0;
      o_mix_rec_en   <= 1'b0;
      o_err          <= 1'b0;
    end else begin
      rec_q        <= i_rec_btn;
      play_q       <= i_play_btn;
      mix_q        <= i_mix_btn;
      stop_q       <= i_stop_btn;
      trig_q       <= i_trig;
      o_rec_start  <= 1'b0;
      o_play_start <= 1'b0;
      o_mix_start  <= 1'b0;
      o_stop       <= 1'b0;
      o_err        <= 1'b0;
      case (state_q)
        IDLE:
          if (rec_e) state_q <= REC_ARM;
          else if (play_e) state_q <= PLAY;
          else if (mix_e) begin
            state_q      <= MIX;
            o_mix_mask   <= '0;
            o_mix_rec_en <= sw_one;
            o_mix_start  <= 1'b1;
            if (sw_one) o_mix_rec_addr <= sw_addr;
          end
        REC_ARM:
          if (stop_e) state_q <= IDLE;
          else if (sw_one) begin
            state_q     <= REC;
            o_rec_addr  <= sw_addr;
            o_rec_start <= 1'b1;
          end
        REC:
          if (stop_e) begin
            state_q <= DRAIN;
            src_q   <= REC;
            wd_q    <= '0;
            o_stop  <= 1'b1;
          end else if (i_rec_done) state_q <= IDLE;
        PLAY:
          if (stop_e) begin
            state_q <= DRAIN;
            src_q   <= PLAY;
            wd_q    <= '0;
            o_stop  <= 1'b1;
          end else if (|trig_e) begin
            o_play_addr  <= trig_addr;
            o_play_speed <= i_speed;
            o_play_start <= 1'b1;
          end else if (i_play_done) state_q <= IDLE;
        MIX: begin
          o_mix_mask <= (o_mix_mask ^ trig_e) & ~i_mute;
          if (stop_e) begin
            state_q <= DRAIN;
            src_q   <= MIX;
            wd_q    <= '0;
            o_stop  <= 1'b1;
          end else if (i_mix_done) state_q <= IDLE;
        end
        DRAIN:
          if (drain_done) state_q <= IDLE;
          else if (wd_end) begin
            state_q <= IDLE;
            o_err   <= 1'b1;
          end else wd_q <= wd_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_loop_control_fsm.sv
// tb_loop_control_fsm: scenario tasks against a chunk-level behavioural model
module tb_loop_control_fsm;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rec_b, play_b, mix_b, stop_b, rec_d, play_d, mix_d;
  logic [7:0] trig, sw, mute;
  logic [1:0] speed;
  logic [2:0] mode;
  logic rec_s, play_s, mix_s, stp, mren, err;
  logic [22:0] rec_a, play_a, mixrec_a;
  logic [1:0] psp;
  logic [7:0] mask;
  logic [15:0] sw16, trig16, mute16;
  logic [2:0] mode2;
  logic rec_s2, play_s2, mix_s2, stp2, mren2, err2;
  logic [22:0] rec_a2, play_a2, mixrec_a2;
  logic [1:0] psp2;
  logic [15:0] mask2;
  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  loop_control_fsm dut (
    .i_clk(clk), .i_rst(rst), .i_rec_btn(rec_b), .i_play_btn(play_b), .i_mix_btn(mix_b),
    .i_stop_btn(stop_b), .i_trig(trig), .i_sw(sw), .i_mute(mute), .i_speed(speed),
    .i_rec_done(rec_d), .i_play_done(play_d), .i_mix_done(mix_d), .o_mode(mode),
    .o_rec_start(rec_s), .o_play_start(play_s), .o_mix_start(mix_s), .o_stop(stp),
    .o_rec_addr(rec_a), .o_play_addr(play_a), .o_mix_rec_addr(mixrec_a),
    .o_play_speed(psp), .o_mix_mask(mask), .o_mix_rec_en(mren), .o_err(err)
  );

  loop_control_fsm #(.NUM_CHUNKS(16), .CHUNK_LOG2(18)) dut16 (
    .i_clk(clk), .i_rst(rst), .i_rec_btn(rec_b), .i_play_btn(play_b), .i_mix_btn(mix_b),
    .i_stop_btn(stop_b), .i_trig(trig16), .i_sw(sw16), .i_mute(mute16), .i_speed(speed),
    .i_rec_done(rec_d), .i_play_done(play_d), .i_mix_done(mix_d), .o_mode(mode2),
    .o_rec_start(rec_s2), .o_play_start(play_s2), .o_mix_start(mix_s2), .o_stop(stp2),
    .o_rec_addr(rec_a2), .o_play_addr(play_a2), .o_mix_rec_addr(mixrec_a2),
    .o_play_speed(psp2), .o_mix_mask(mask2), .o_mix_rec_en(mren2), .o_err(err2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    n_chk++;
    if ({mode, rec_s, play_s, mix_s, stp, rec_a, play_a, mixrec_a, psp, mask, mren, err} !== '0)
      $display("FAIL reset_outputs: mode=%0d rec_a=%h play_a=%h mask=%h err=%b, required all 0",
               mode, rec_a, play_a, mask, err);
    else n_pass++;
    n_chk++;
    if ({mode2, rec_s2, stp2, rec_a2, mask2, err2} !== '0)
      $display("FAIL reset_outputs16: mode=%0d rec_a=%h, required all 0", mode2, rec_a2);
    else n_pass++;
    rst = 1'b0;
    step;
    step;
    n_chk++;
    if (mode !== 3'd0) $display("FAIL reset_idle: mode=%0d required 0", mode);
    else n_pass++;
  endtask

  task automatic test_rec;
    for (int it = 0; it < 4; it++) begin
      int k, w;
      bit bad;
      logic [22:0] ea;
      k = (it == 0) ? 2 : $urandom_range(0, 7);
      w = (it == 0) ? 5 : $urandom_range(1, 6);
      ea = 23'(k << 20);
      sw = 8'h00;
      rec_b = 1'b1;
      step;
      rec_b = 1'b0;
      n_chk++;
      if (mode !== 3'd1) $display("FAIL rec_arm_entry: mode=%0d required 1", mode);
      else n_pass++;
      bad = 1'b0;
      for (int j = 0; j < w; j++) begin
        sw = (it == 0 || j % 2 == 0) ? 8'h00 : 8'(8'h03 << $urandom_range(0, 6));
        step;
        if (rec_s !== 1'b0 || mode !== 3'd1) bad = 1'b1;
      end
      n_chk++;
      if (bad) $display("FAIL rec_arm_wait: start or exit without one-hot sw (last mode=%0d)", mode);
      else n_pass++;
      sw = 8'(1 << k);
      step;
      n_chk++;
      if (rec_s !== 1'b1 || rec_a !== ea || mode !== 3'd2)
        $display("FAIL rec_start: start=%b addr=%h mode=%0d required 1 %h 2", rec_s, rec_a, mode, ea);
      else n_pass++;
      step;
      n_chk++;
      if (rec_s !== 1'b0 || rec_a !== ea)
        $display("FAIL rec_single_pulse: start=%b addr=%h required 0 %h", rec_s, rec_a, ea);
      else n_pass++;
      rec_d = 1'b1;
      step;
      rec_d = 1'b0;
      n_chk++;
      if (mode !== 3'd0) $display("FAIL rec_done: mode=%0d required 0", mode);
      else n_pass++;
    end
    sw = 8'h00;
  endtask

  task automatic test_play;
    logic [22:0] ea;
    logic [1:0] es;
    logic [7:0] t, m, e;
    int idx;
    trig = 8'h00;
    mute = 8'h00;
    play_b = 1'b1;
    step;
    play_b = 1'b0;
    speed = 2'd2;
    trig = 8'h0A;
    step;
    n_chk++;
    if (play_s !== 1'b1 || play_a !== 23'h100000 || psp !== 2'd2 || mode !== 3'd3)
      $display("FAIL play_lowest: start=%b addr=%h speed=%0d mode=%0d required 1 100000 2 3",
               play_s, play_a, psp, mode);
    else n_pass++;
    step;
    n_chk++;
    if (play_s !== 1'b0) $display("FAIL play_held_trig: start=%b required 0", play_s);
    else n_pass++;
    trig = 8'h00;
    step;
    mute = 8'h02;
    speed = 2'd1;
    trig = 8'h0A;
    step;
    n_chk++;
    if (play_s !== 1'b1 || play_a !== 23'h300000 || psp !== 2'd1)
      $display("FAIL play_muted: start=%b addr=%h speed=%0d required 1 300000 1", play_s, play_a, psp);
    else n_pass++;
    ea = 23'h300000;
    es = 2'd1;
    for (int it = 0; it < 8; it++) begin
      trig = 8'h00;
      step;
      t = 8'($urandom);
      m = 8'($urandom & $urandom);
      mute = m;
      speed = 2'($urandom);
      trig = t;
      e = t & ~m;
      step;
      if (e != 0) begin
        idx = 0;
        for (int i = 7; i >= 0; i--) if (e[i]) idx = i;
        ea = 23'(idx << 20);
        es = speed;
      end
      n_chk++;
      if (play_s !== (e != 0) || play_a !== ea || psp !== es)
        $display("FAIL play_random: trig=%h mute=%h start=%b addr=%h speed=%0d required %b %h %0d",
                 t, m, play_s, play_a, psp, e != 0, ea, es);
      else n_pass++;
    end
    trig = 8'h00;
    mute = 8'h00;
    step;
    trig = 8'h01;
    play_d = 1'b1;
    step;
    play_d = 1'b0;
    n_chk++;
    if (play_s !== 1'b1 || mode !== 3'd3 || play_a !== 23'h000000)
      $display("FAIL play_start_beats_done: start=%b mode=%0d addr=%h required 1 3 0", play_s, mode, play_a);
    else n_pass++;
    trig = 8'h00;
    play_d = 1'b1;
    step;
    play_d = 1'b0;
    n_chk++;
    if (mode !== 3'd0) $display("FAIL play_done: mode=%0d required 0", mode);
    else n_pass++;
  endtask

  task automatic test_mix;
    logic [7:0] em, t, m;
    trig = 8'h00;
    mute = 8'h00;
    sw = 8'h80;
    mix_b = 1'b1;
    step;
    mix_b = 1'b0;
    n_chk++;
    if (mix_s !== 1'b1 || mask !== 8'h00 || mren !== 1'b1 || mixrec_a !== 23'h700000 || mode !== 3'd4)
      $display("FAIL mix_entry: start=%b mask=%h en=%b addr=%h mode=%0d required 1 00 1 700000 4",
               mix_s, mask, mren, mixrec_a, mode);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      trig = (i == 1) ? 8'h04 : 8'h01;
      step;
      trig = 8'h00;
      step;
    end
    n_chk++;
    if (mask !== 8'h04 || mix_s !== 1'b0) $display("FAIL mix_toggle: mask=%h start=%b required 04 0", mask, mix_s);
    else n_pass++;
    mute = 8'h04;
    step;
    n_chk++;
    if (mask !== 8'h00) $display("FAIL mix_mute_clear: mask=%h required 00", mask);
    else n_pass++;
    em = 8'h00;
    for (int it = 0; it < 10; it++) begin
      t = 8'($urandom);
      m = 8'($urandom & $urandom);
      mute = m;
      trig = t;
      step;
      for (int i = 0; i < 8; i++) em[i] = m[i] ? 1'b0 : (t[i] ? ~em[i] : em[i]);
      trig = 8'h00;
      step;
      for (int i = 0; i < 8; i++) if (m[i]) em[i] = 1'b0;
      n_chk++;
      if (mask !== em) $display("FAIL mix_random: trig=%h mute=%h mask=%h required %h", t, m, mask, em);
      else n_pass++;
    end
    mute = 8'h00;
    mix_d = 1'b1;
    step;
    mix_d = 1'b0;
    n_chk++;
    if (mode !== 3'd0) $display("FAIL mix_done: mode=%0d required 0", mode);
    else n_pass++;
    sw = 8'h00;
    mix_b = 1'b1;
    step;
    mix_b = 1'b0;
    n_chk++;
    if (mix_s !== 1'b1 || mren !== 1'b0 || mixrec_a !== 23'h700000 || mask !== 8'h00)
      $display("FAIL mix_no_rec: start=%b en=%b addr=%h mask=%h required 1 0 700000 00",
               mix_s, mren, mixrec_a, mask);
    else n_pass++;
    stop_b = 1'b1;
    step;
    stop_b = 1'b0;
    n_chk++;
    if (stp !== 1'b1 || mode !== 3'd5) $display("FAIL mix_stop: stop=%b mode=%0d required 1 5", stp, mode);
    else n_pass++;
    play_d = 1'b1;
    step;
    play_d = 1'b0;
    n_chk++;
    if (mode !== 3'd5) $display("FAIL drain_wrong_done: mode=%0d required 5", mode);
    else n_pass++;
    mix_d = 1'b1;
    step;
    mix_d = 1'b0;
    n_chk++;
    if (mode !== 3'd0 || err !== 1'b0) $display("FAIL drain_mix_done: mode=%0d err=%b required 0 0", mode, err);
    else n_pass++;
  endtask

  task automatic test_drain_timeout;
    int n, sc;
    trig = 8'h00;
    mute = 8'h00;
    play_b = 1'b1;
    step;
    play_b = 1'b0;
    trig = 8'h01;
    stop_b = 1'b1;
    step;
    stop_b = 1'b0;
    trig = 8'h00;
    n_chk++;
    if (stp !== 1'b1 || play_s !== 1'b0 || mode !== 3'd5)
      $display("FAIL stop_beats_trig: stop=%b start=%b mode=%0d required 1 0 5", stp, play_s, mode);
    else n_pass++;
    n = 1;
    sc = 0;
    for (int i = 0; i < 2000 && mode == 3'd5; i++) begin
      step;
      if (mode == 3'd5) n++;
      if (stp) sc++;
    end
    n_chk++;
    if (n != 1024 || sc != 0 || mode !== 3'd0 || err !== 1'b1)
      $display("FAIL drain_timeout: cycles=%0d stops=%0d mode=%0d err=%b required 1024 0 0 1", n, sc, mode, err);
    else n_pass++;
    step;
    n_chk++;
    if (err !== 1'b0) $display("FAIL err_pulse: err=%b required 0", err);
    else n_pass++;
    play_b = 1'b1;
    step;
    play_b = 1'b0;
    stop_b = 1'b1;
    step;
    stop_b = 1'b0;
    for (int i = 1; i < 1024; i++) begin
      rec_d = (i == 100);
      mix_d = (i == 200);
      step;
    end
    rec_d = 1'b0;
    mix_d = 1'b0;
    n_chk++;
    if (mode !== 3'd5) $display("FAIL drain_last_cycle: mode=%0d required 5", mode);
    else n_pass++;
    play_d = 1'b1;
    step;
    play_d = 1'b0;
    n_chk++;
    if (mode !== 3'd0 || err !== 1'b0) $display("FAIL done_beats_timeout: mode=%0d err=%b required 0 0", mode, err);
    else n_pass++;
    step;
    n_chk++;
    if (err !== 1'b0 || mode !== 3'd0) $display("FAIL no_late_err: err=%b mode=%0d required 0 0", err, mode);
    else n_pass++;
  endtask

  task automatic test_priority;
    bit bad;
    sw = 8'h00;
    rec_b = 1'b1;
    play_b = 1'b1;
    mix_b = 1'b1;
    step;
    n_chk++;
    if (mode !== 3'd1 || mix_s !== 1'b0) $display("FAIL btn_priority: mode=%0d mix_start=%b required 1 0", mode, mix_s);
    else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step;
      if (mode !== 3'd1 || rec_s || play_s || mix_s || stp) bad = 1'b1;
    end
    n_chk++;
    if (bad) $display("FAIL held_rec_arm: mode=%0d required steady 1", mode);
    else n_pass++;
    stop_b = 1'b1;
    step;
    n_chk++;
    if (mode !== 3'd0 || stp !== 1'b0) $display("FAIL arm_stop: mode=%0d stop=%b required 0 0", mode, stp);
    else n_pass++;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step;
      if (mode !== 3'd0 || rec_s || play_s || mix_s || stp) bad = 1'b1;
    end
    n_chk++;
    if (bad) $display("FAIL held_idle: mode=%0d required steady 0", mode);
    else n_pass++;
    rec_b = 1'b0;
    play_b = 1'b0;
    mix_b = 1'b0;
    stop_b = 1'b0;
    step;
  endtask

  task automatic test_reset_mid;
    rst = 1'b1;
    step;
    rst = 1'b0;
    sw = 8'h10;
    sw16 = 16'h8000;
    rec_b = 1'b1;
    step;
    rec_b = 1'b0;
    step;
    n_chk++;
    if (rec_s2 !== 1'b1 || rec_a2 !== 23'h3C0000 || mode2 !== 3'd2)
      $display("FAIL rec16_addr: start=%b addr=%h mode=%0d required 1 3c0000 2", rec_s2, rec_a2, mode2);
    else n_pass++;
    n_chk++;
    if (rec_a !== 23'h400000 || mode !== 3'd2) $display("FAIL rec_bit4: addr=%h mode=%0d required 400000 2", rec_a, mode);
    else n_pass++;
    step;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({mode, rec_s, play_s, mix_s, stp, rec_a, play_a, mixrec_a, psp, mask, mren, err} !== '0 ||
        {mode2, stp2, rec_a2} !== '0)
      $display("FAIL async_reset: mode=%0d rec_a=%h mode16=%0d rec_a16=%h required all 0", mode, rec_a, mode2, rec_a2);
    else n_pass++;
    step;
    rst = 1'b0;
    sw = 8'h00;
    sw16 = 16'h0000;
    step;
    n_chk++;
    if (mode !== 3'd0 || stp !== 1'b0 || rec_s !== 1'b0)
      $display("FAIL reset_no_stop: mode=%0d stop=%b start=%b required 0 0 0", mode, stp, rec_s);
    else n_pass++;
  endtask

  initial begin
    {rec_b, play_b, mix_b, stop_b, rec_d, play_d, mix_d} = '0;
    trig = 8'h00;
    sw = 8'h00;
    mute = 8'h00;
    speed = 2'd0;
    sw16 = 16'h0000;
    trig16 = 16'h0000;
    mute16 = 16'h0000;
    #1;
    test_reset;
    test_rec;
    test_play;
    test_mix;
    test_drain_timeout;
    test_priority;
    test_reset_mid;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/loop_control_fsm.md
Name: loop_control_fsm

Overview:
Parametrised top-level transport controller for the looper. It replaces the level-driven 8-chunk control core with an N-chunk, edge-triggered FSM that emits single-cycle start/stop pulses and computes chunk base addresses arithmetically. It adds per-chunk mute, a toggle-accumulated mix mask, and a stop-drain watchdog. It sits between the GPIO/switch front end and the record, play and mix engines.

Parameters:
NUM_CHUNKS, 8, number of SDRAM loop chunks / pads (2..16)
ADDR_W, 23, SDRAM word-address width
CHUNK_LOG2, 20, log2 of chunk size in words; chunk base = idx << CHUNK_LOG2
TIMEOUT_CYC, 1024, maximum cycles allowed in DRAIN before forced abort

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-high
i_rec_btn / i_play_btn / i_mix_btn / i_stop_btn  in  1 each  level buttons, pre-synchronised
i_trig  in  NUM_CHUNKS  pad trigger levels
i_sw  in  NUM_CHUNKS  record-target select switches
i_mute  in  NUM_CHUNKS  per-chunk mute
i_speed  in  2  playback speed code
i_rec_done / i_play_done / i_mix_done  in  1 each  engine completion pulses
o_mode  out  3  0 IDLE, 1 REC_ARM, 2 REC, 3 PLAY, 4 MIX, 5 DRAIN
o_rec_start / o_play_start / o_mix_start / o_stop  out  1 each  single-cycle command pulses
o_rec_addr / o_play_addr / o_mix_rec_addr  out  ADDR_W  chunk base addresses
o_play_speed  out  2  speed, latched at each play start
o_mix_mask  out  NUM_CHUNKS  active mix sources
o_mix_rec_en  out  1  mix result is written to a chunk
o_err  out  1  single-cycle pulse on watchdog abort

Behaviour:
- Reset: all outputs are 0, state IDLE, edge registers are 0, watchdog is 0. Reset mid-operation aborts immediately with no o_stop pulse.
- Rising-edge detect on all buttons and i_trig: one registered copy per bit; edge = cur & ~prev.
- "one-hot(v)" means exactly one bit of v is set. idx = position of that bit. Address = idx zero-extended << CHUNK_LOG2. ADDR_W must be >= CHUNK_LOG2 + clog2(NUM_CHUNKS).
- IDLE: on a button edge, priority is REC > PLAY > MIX. A stop edge is ignored.
- REC_ARM: wait until one-hot(i_sw). Then, in the same cycle, drive o_rec_addr and pulse o_rec_start, and go to REC. A stop edge before that returns to IDLE with no pulse.
- REC: i_rec_done -> IDLE. A stop edge pulses o_stop and goes to DRAIN.
- PLAY: trig edges are masked by ~i_mute. If any edge remains, the lowest index wins: o_play_addr and o_play_speed are latched and o_play_start pulses. Retrigger during playback is allowed. i_play_done -> IDLE, unless a start pulses in the same cycle, in which case the start wins and the state stays PLAY. A stop edge pulses o_stop and goes to DRAIN; a stop edge beats a trigger in the same cycle.
- MIX entry (first cycle):
  - o_mix_mask = 0.
  - o_mix_rec_en = one-hot(i_sw); if set, o_mix_rec_addr is latched from i_sw.
  - o_mix_start pulses once.
- MIX steady state: each unmuted trig edge toggles its mask bit. Asserting i_mute clears that mask bit on the next cycle. i_mix_done -> IDLE. A stop edge pulses o_stop and goes to DRAIN.
- DRAIN:
  - The watchdog counts from 0.
  - Only the done signal of the interrupted operation is honoured; it returns to IDLE.
  - When the count reaches TIMEOUT_CYC-1: return to IDLE and pulse o_err.
  - If done and timeout occur in the same cycle, done wins and there is no o_err.
- Addresses, mask and rec_en hold their values until the next relevant start or reset. Start pulses are never asserted in consecutive cycles for the same trigger edge.
- Latency: button or trig edge at cycle n (registered input) -> pulse at cycle n+1 after the edge register.

Test Plan:
- Rec edge, then i_sw=0 for 5 cycles, then i_sw=8'h04 -> o_rec_start pulses once with o_rec_addr=23'h200000. i_rec_done -> o_mode=0.
- PLAY with i_trig rising 8'h0A in one cycle and i_mute=0 -> one o_play_start with o_play_addr=23'h100000 (idx 1). Same pattern with i_mute=8'h02 -> addr 23'h300000.
- MIX with i_sw=8'h80: triggers on 0, 2, 0 -> o_mix_mask=8'h04, o_mix_rec_en=1, o_mix_rec_addr=23'h700000. Then i_mute[2]=1 -> mask 0 next cycle.
- PLAY, stop edge, no done -> o_stop pulse, o_mode=5 for 1024 cycles, o_err pulse, o_mode=0. Repeat with i_play_done at cycle 1023 -> o_err stays 0.
- Simultaneous rec+play+mix edges in IDLE -> REC_ARM. Held buttons for 100 cycles -> no further transitions.
- i_rst asserted mid-REC -> all outputs 0 asynchronously and no o_stop. With NUM_CHUNKS=16, CHUNK_LOG2=18 and i_sw bit 15 -> o_rec_addr=23'h3C0000.
